// File: rtl/mb_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : mb_scan_pkg
// Desc   : Shared constants and one-hot FSM state type for the MB scan sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package mb_scan_pkg;

    localparam int MB_BITS_DEFAULT    = 10;
    localparam int SETTLE_CYC_DEFAULT = 2;
    localparam int CNT_BITS           = 4;

    localparam logic [5:0] ST_IDLE   = 6'h01;
    localparam logic [5:0] ST_LAUNCH = 6'h02;
    localparam logic [5:0] ST_RUN    = 6'h04;
    localparam logic [5:0] ST_LOAD   = 6'h08;
    localparam logic [5:0] ST_SETTLE = 6'h10;
    localparam logic [5:0] ST_DONE   = 6'h20;

    typedef enum logic [5:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_RUN    = ST_RUN,
        S_LOAD   = ST_LOAD,
        S_SETTLE = ST_SETTLE,
        S_DONE   = ST_DONE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mb_pos_counter.sv
`default_nettype none
// ============================================================================
// Module : mb_pos_counter
// Desc   : Raster x/y position registers with clear, advance and last-MB flag.
// Rev    : 1.0 - initial release
// ============================================================================
module mb_pos_counter
    import mb_scan_pkg::*;
#(
    parameter int MB_BITS = MB_BITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               adv_i,
    input  logic [MB_BITS-1:0] w1_i,
    input  logic [MB_BITS-1:0] h1_i,
    output logic [MB_BITS-1:0] x_o,
    output logic [MB_BITS-1:0] y_o,
    output logic               last_o
);

    logic [MB_BITS-1:0] x_q;
    logic [MB_BITS-1:0] y_q;
    logic               w_x_wrap;

    // Compare against w1/h1 only so a 1023-wide frame never overflows x.
    assign w_x_wrap = (x_q == w1_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (adv_i) begin
            if (w_x_wrap) begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = w_x_wrap && (y_q == h1_i);

endmodule
`default_nettype wire

// File: rtl/mb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mb_scan_ctrl
// Desc   : Macroblock raster-scan sequencer: launches MBs, pulses the boundary
//          saver load and enforces its settle time. Optional MB_SCAN_PERF_EN
//          adds a busy-cycle counter output.
// Rev    : 1.0 - initial release
// ============================================================================
module mb_scan_ctrl
    import mb_scan_pkg::*;
#(
    parameter int MB_BITS    = MB_BITS_DEFAULT,
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start_i,
    input  logic [MB_BITS-1:0] mb_w_i,
    input  logic [MB_BITS-1:0] mb_h_i,
    input  logic               mb_done_i,
    output logic               mb_start_o,
    output logic               load_o,
    output logic [MB_BITS-1:0] x_o,
    output logic [MB_BITS-1:0] y_o,
    output logic [MB_BITS-1:0] w1_o,
    output logic [MB_BITS-1:0] w2_o,
    output logic [MB_BITS-1:0] h1_o,
    output logic               busy_o,
    output logic               frame_done_o
`ifdef MB_SCAN_PERF_EN
    ,
    output logic [31:0]        perf_cycles_o
`endif
);

    localparam logic [CNT_BITS-1:0] c_SETTLE_LOAD = CNT_BITS'(SETTLE_CYC - 1);

    state_e              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                mb_start_q;
    logic                load_q;
    logic                busy_q;
    logic                frame_done_q;
    logic [MB_BITS-1:0]  w1_q;
    logic [MB_BITS-1:0]  w2_q;
    logic [MB_BITS-1:0]  h1_q;

    logic                w_dims_ok;
    logic                w_accept;
    logic                w_adv;
    logic                w_last;

    assign w_dims_ok = (mb_w_i != '0) && (mb_h_i != '0);
    assign w_accept  = (state_q == S_IDLE) && frame_start_i && w_dims_ok;
    assign w_adv     = (state_q == S_LOAD);

    mb_pos_counter #(
        .MB_BITS (MB_BITS)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (w_accept),
        .adv_i  (w_adv),
        .w1_i   (w1_q),
        .h1_i   (h1_q),
        .x_o    (x_o),
        .y_o    (y_o),
        .last_o (w_last)
    );

    // Pulse outputs are registered on the transition so that mb_start lands
    // two cycles after frame_start and SETTLE_CYC+1 cycles after load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mb_start_q   <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            w1_q         <= '0;
            w2_q         <= '0;
            h1_q         <= '0;
        end else begin
            mb_start_q   <= 1'b0;
            load_q       <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        if (w_dims_ok) begin
                            w1_q    <= mb_w_i - 1'b1;
                            w2_q    <= mb_w_i - MB_BITS'(2);
                            h1_q    <= mb_h_i - 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_LAUNCH;
                        end else begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    mb_start_q <= 1'b1;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (mb_done_i) begin
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        cnt_q   <= c_SETTLE_LOAD;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_BITS'(1)) begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mb_start_o   = mb_start_q;
    assign load_o       = load_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign w1_o         = w1_q;
    assign w2_o         = w2_q;
    assign h1_o         = h1_q;

`ifdef MB_SCAN_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (w_accept) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mb_scan_ctrl
// Desc   : Self-checking bench for mb_scan_ctrl: event-schedule model checked
//          every cycle plus literal expectations per directed scenario.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mb_scan_ctrl;

    localparam int MB_BITS = 10;
    localparam int SETTLE  = 2;
    localparam int WRAP    = 1 << MB_BITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               frame_start_i = 1'b0;
    logic               mb_done_i = 1'b0;
    logic [MB_BITS-1:0] mb_w_i = '0;
    logic [MB_BITS-1:0] mb_h_i = '0;
    logic               mb_start_o, load_o, busy_o, frame_done_o;
    logic [MB_BITS-1:0] x_o, y_o, w1_o, w2_o, h1_o;
`ifdef MB_SCAN_PERF_EN
    logic [31:0]        perf_cycles_o;
`endif

    always #5 clk = ~clk;

    mb_scan_ctrl #(
        .MB_BITS    (MB_BITS),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start_i),
        .mb_w_i        (mb_w_i),
        .mb_h_i        (mb_h_i),
        .mb_done_i     (mb_done_i),
        .mb_start_o    (mb_start_o),
        .load_o        (load_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .w1_o          (w1_o),
        .w2_o          (w2_o),
        .h1_o          (h1_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o)
`ifdef MB_SCAN_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: expected output values for the current cycle plus the cycle
    // numbers at which each pulse is due.
    bit     m_busy;
    bit     m_run;
    int     m_x, m_y, m_w1, m_w2, m_h1, m_W, m_H, m_idx;
    int     m_start_cyc, m_load_cyc, m_fdone_cyc;
    longint m_perf;

    int start_log[$];
    int load_cyc_log[$];
    int load_x_log[$];
    int load_y_log[$];
    int fdone_log[$];
    int xafter_log[$];
    int busy_cnt;
    bit prev_load;

    bit eng_en  = 1'b0;
    int eng_lat = 3;
    bit spur_en = 1'b0;
    int fs_cyc;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_run = 0;
        m_x = 0; m_y = 0; m_w1 = 0; m_w2 = 0; m_h1 = 0;
        m_W = 1; m_H = 1; m_idx = 0;
        m_start_cyc = -1; m_load_cyc = -1; m_fdone_cyc = -1;
        m_perf = 0;
    endtask

    task automatic model_step();
        bit busy_now;
        bit accept;
        busy_now = m_busy;
        accept   = 0;
        if (frame_start_i && !busy_now) begin
            if (mb_w_i != 0 && mb_h_i != 0) begin
                accept = 1;
                m_W = int'(mb_w_i); m_H = int'(mb_h_i);
                m_w1 = (m_W - 1) % WRAP;
                m_w2 = (m_W - 2 + WRAP) % WRAP;
                m_h1 = (m_H - 1) % WRAP;
                m_idx = 0; m_x = 0; m_y = 0;
                m_busy = 1; m_run = 1;
                m_start_cyc = cyc + 2;
            end else begin
                m_fdone_cyc = cyc + 1;
            end
        end
        if (mb_done_i && m_run && cyc >= m_start_cyc) begin
            m_run = 0;
            m_load_cyc = cyc + 1;
            if (m_idx == m_W * m_H - 1) begin
                m_fdone_cyc = cyc + 2;
            end else begin
                m_start_cyc = cyc + 2 + SETTLE;
                m_run = 1;
            end
        end
        if (cyc == m_load_cyc) begin
            m_idx++;
            m_x = m_idx % m_W;
            m_y = (m_idx / m_W) % WRAP;
        end
        if (cyc == m_fdone_cyc && busy_now) m_busy = 0;
        if (accept) m_perf = 0;
        else if (busy_now && m_perf != 64'hFFFF_FFFF) m_perf++;
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            check("mb_start",   mb_start_o,   cyc == m_start_cyc);
            check("load",       load_o,       cyc == m_load_cyc);
            check("frame_done", frame_done_o, cyc == m_fdone_cyc);
            check("busy",       busy_o,       m_busy);
            check("x",          x_o,          m_x);
            check("y",          y_o,          m_y);
            check("w1",         w1_o,         m_w1);
            check("w2",         w2_o,         m_w2);
            check("h1",         h1_o,         m_h1);
`ifdef MB_SCAN_PERF_EN
            check("perf",       perf_cycles_o, m_perf);
`endif
            if (mb_start_o) start_log.push_back(cyc);
            if (load_o) begin
                load_cyc_log.push_back(cyc);
                load_x_log.push_back(int'(x_o));
                load_y_log.push_back(int'(y_o));
            end
            if (frame_done_o) fdone_log.push_back(cyc);
            if (prev_load) xafter_log.push_back(int'(x_o));
            if (busy_o) busy_cnt++;
            prev_load = load_o;
            model_step();
        end
        cyc++;
    end

    task automatic clear_logs();
        start_log.delete(); load_cyc_log.delete(); load_x_log.delete();
        load_y_log.delete(); fdone_log.delete(); xafter_log.delete();
        busy_cnt = 0;
    endtask

    task automatic drive(input bit fs, input bit md);
        @(posedge clk); #1;
        frame_start_i = fs;
        mb_done_i = md
            || (eng_en && m_start_cyc >= 0 && cyc == m_start_cyc + eng_lat)
            || (spur_en && m_load_cyc >= 0 && cyc == m_load_cyc + 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(0, 0);
    endtask

    task automatic start_frame(input int w, input int h, input int lat);
        clear_logs();
        eng_lat = lat; eng_en = 1;
        mb_w_i = MB_BITS'(w); mb_h_i = MB_BITS'(h);
        drive(1, 0);
        fs_cyc = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        model_reset();
        prev_load = 0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", busy_o, 0);
        check("rst_x", x_o, 0);
        check("rst_w2", w2_o, 0);
        check("rst_mb_start", mb_start_o, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic 2x2 frame, engine latency 3
        start_frame(2, 2, 3);
        idle_cycles(45);
        check("b22_starts", start_log.size(), 4);
        check("b22_first_start", start_log[0] - fs_cyc, 2);
        check("b22_loads", load_cyc_log.size(), 4);
        check("b22_first_load", load_cyc_log[0] - fs_cyc, 6);
        check("b22_ld0", load_x_log[0] * 10 + load_y_log[0], 0);
        check("b22_ld1", load_x_log[1] * 10 + load_y_log[1], 10);
        check("b22_ld2", load_x_log[2] * 10 + load_y_log[2], 1);
        check("b22_ld3", load_x_log[3] * 10 + load_y_log[3], 11);
        check("b22_fdone_cnt", fdone_log.size(), 1);
        check("b22_fdone_gap", fdone_log[0] - load_cyc_log[3], 1);
        check("b22_w1", w1_o, 1);
        check("b22_w2", w2_o, 0);
        check("b22_h1", h1_o, 1);

        // Single MB frame
        start_frame(1, 1, 3);
        idle_cycles(15);
        check("b11_w2", w2_o, 10'h3FF);
        check("b11_starts", start_log.size(), 1);
        check("b11_loads", load_cyc_log.size(), 1);
        check("b11_fdone", fdone_log.size() == 1 ? fdone_log[0] - fs_cyc : -1, 7);
        check("b11_busy_cycles", busy_cnt, 7);

        // Settle spacing with an immediate engine
        start_frame(3, 1, 1);
        idle_cycles(25);
        check("set_loads", load_cyc_log.size(), 3);
        check("set_gap", start_log[1] - load_cyc_log[0], 3);
        check("set_x_after", xafter_log[0], 1);

        // Zero-dimension frame_start
        start_frame(0, 3, 3);
        idle_cycles(5);
        check("zero_fdone_cnt", fdone_log.size(), 1);
        check("zero_fdone_gap", fdone_log[0] - fs_cyc, 1);
        check("zero_starts", start_log.size(), 0);
        check("zero_busy", busy_cnt, 0);

        // Busy frame_start, dimension change and mb_done during SETTLE
        spur_en = 1;
        start_frame(3, 1, 3);
        idle_cycles(3);
        mb_w_i = 10'd2; mb_h_i = 10'd2;
        drive(1, 0);
        mb_w_i = 10'd7;
        idle_cycles(35);
        spur_en = 0;
        check("busy_starts", start_log.size(), 3);
        check("busy_loads", load_cyc_log.size(), 3);
        check("busy_fdone", fdone_log.size(), 1);
        check("busy_w1", w1_o, 2);

        // Reset in RUN of MB (1,0) of a 3x2 frame
        start_frame(3, 2, 6);
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            drive(0, 0);
            if (m_idx == 1 && m_start_cyc >= 0 && cyc == m_start_cyc + 2) reached = 1;
        end
        check("rm_reached_run", reached, 1);
        rst_n = 1'b0;
        #1;
        check("rm_busy", busy_o, 0);
        check("rm_x", x_o, 0);
        check("rm_y", y_o, 0);
        check("rm_w1", w1_o, 0);
        check("rm_h1", h1_o, 0);
        check("rm_load", load_o, 0);
        check("rm_fdone", frame_done_o, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        clear_logs();
        drive(0, 1);
        idle_cycles(3);
        check("rm_stray_load", load_cyc_log.size(), 0);
        start_frame(2, 1, 2);
        idle_cycles(25);
        check("rm_restart_loads", load_cyc_log.size(), 2);
        check("rm_restart_pos", load_x_log[0] * 10 + load_y_log[0], 0);

`ifdef MB_SCAN_PERF_EN
        start_frame(2, 1, 4);
        idle_cycles(25);
        check("perf_literal", perf_cycles_o, 16);
        check("perf_vs_busy", perf_cycles_o, busy_cnt);
        idle_cycles(5);
        check("perf_hold", perf_cycles_o, 16);
        start_frame(1, 1, 3);
        drive(0, 0);
        check("perf_clear", perf_cycles_o, 0);
        idle_cycles(15);
`endif

        eng_en = 0;
        idle_cycles(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
